// File: rtl/sync_frame_serializer.sv
// Parallel words in on valid/ready, serial frames out: SYNC_PAT, payload MSB-first, GAP_CYC idle zeros.
// Define SYNC_SER_PARITY_EN to append an even-parity bit after the payload and end the frame on it.
module sync_frame_serializer #(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1010,
   parameter int                GAP_CYC  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din_data,
   output logic              din_ready,
   output logic              dout,
   output logic              dout_active,
   output logic              frame_last
);

   localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int MAX_G   = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
   localparam int MAX_ALL = (MAX_G > 2) ? MAX_G : 2;
   localparam int CNT_W   = $clog2(MAX_ALL);

   localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SYNC_SER_PARITY_EN
   typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              din_ready_q, din_ready_d;
   logic              dout_q, dout_d;
   logic              dout_active_q, dout_active_d;
   logic              frame_last_q, frame_last_d;
   logic [SYNC_W-1:0] sync_mask;
   logic [DATA_W-1:0] data_mask;

   // Next-state: every state leaves on count 0, so counters never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (din_valid && din_ready_q) begin
               state_d = SYNC;
               cnt_d   = SYNC_LD;
               data_d  = din_data;
            end
         end
         SYNC: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = DATA_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
`ifdef SYNC_SER_PARITY_EN
               state_d = PAR;
`else
               state_d = (GAP_CYC > 0) ? GAP : IDLE;
               cnt_d   = GAP_LD;
`endif
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`ifdef SYNC_SER_PARITY_EN
         PAR: begin
            state_d = (GAP_CYC > 0) ? GAP : IDLE;
            cnt_d   = GAP_LD;
         end
`endif
         GAP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are a function of the state being entered, so they register alongside it.
   always_comb begin
      sync_mask     = SYNC_W'(1) << cnt_d;
      data_mask     = DATA_W'(1) << cnt_d;
      din_ready_d   = (state_d == IDLE);
      dout_d        = 1'b0;
      dout_active_d = 1'b0;
      frame_last_d  = 1'b0;
      case (state_d)
         SYNC: begin
            dout_d        = |(SYNC_PAT & sync_mask);
            dout_active_d = 1'b1;
         end
         DATA: begin
            dout_d        = |(data_d & data_mask);
            dout_active_d = 1'b1;
`ifndef SYNC_SER_PARITY_EN
            frame_last_d  = (cnt_d == '0);
`endif
         end
`ifdef SYNC_SER_PARITY_EN
         PAR: begin
            dout_d        = ^data_d;
            dout_active_d = 1'b1;
            frame_last_d  = 1'b1;
         end
`endif
         default: begin
            dout_d        = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         data_q        <= '0;
         din_ready_q   <= 1'b0;
         dout_q        <= 1'b0;
         dout_active_q <= 1'b0;
         frame_last_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         din_ready_q   <= din_ready_d;
         dout_q        <= dout_d;
         dout_active_q <= dout_active_d;
         frame_last_q  <= frame_last_d;
      end
   end

   assign din_ready   = din_ready_q;
   assign dout        = dout_q;
   assign dout_active = dout_active_q;
   assign frame_last  = frame_last_q;

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Bench for sync_frame_serializer: default instance plus a GAP_CYC=0 / 1-bit payload instance.
module tb_sync_frame_serializer;

`ifdef SYNC_SER_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int GAP = 2;
   localparam int F   = 12 + PAR_EN;

   logic       clk;
   logic       resetn;
   logic       din_valid;
   logic [7:0] din_data;
   logic       din_ready, dout, dout_active, frame_last;
   logic       b_valid, b_data;
   logic       b_ready, b_dout, b_active, b_last;

   sync_frame_serializer u_dut (
      .clk(clk), .resetn(resetn), .din_valid(din_valid), .din_data(din_data),
      .din_ready(din_ready), .dout(dout), .dout_active(dout_active), .frame_last(frame_last)
   );

   sync_frame_serializer #(.DATA_W(1), .SYNC_W(2), .SYNC_PAT(2'b11), .GAP_CYC(0)) u_dut_b (
      .clk(clk), .resetn(resetn), .din_valid(b_valid), .din_data(b_data),
      .din_ready(b_ready), .dout(b_dout), .dout_active(b_active), .frame_last(b_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  word;
      logic [11:0] bits;
      logic        par;
   } vec_t;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   vec_t tbl[9];
   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   idle_run = 0;
   int   last_gap = 0;
   int   frames_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
   endtask

   task automatic push_frame(input vec_t v);
      for (int i = 11; i >= 0; i--) exp_q.push_back('{b: v.bits[i], last: (i == 0) && (PAR_EN == 0)});
      if (PAR_EN != 0) exp_q.push_back('{b: v.par, last: 1'b1});
   endtask

   // Scoreboard: every active serial bit must match the next queued expectation.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         idle_run = 0;
      end else begin
         if (dout_active) begin
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 0, 1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("dout", dout, e.b);
               chk("frame_last", frame_last, e.last);
            end
         end else begin
            idle_run++;
            chk("idle_dout", dout, 0);
            chk("idle_last", frame_last, 0);
         end
         if (frame_last) frames_seen++;
      end
   end

   task automatic wait_ready(output bit hit);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (din_ready) hit = 1;
      end
      if (!hit) chk("handshake_timeout", 0, 1);
   endtask

   task automatic drive_word(input vec_t v);
      bit hit;
      @(posedge clk); #1;
      din_valid = 1'b1;
      din_data  = v.word;
      wait_ready(hit);
      if (hit) push_frame(v);
      @(posedge clk); #1;
      din_valid = 1'b0;
      din_data  = 8'($urandom);
   endtask

   // Scrambles din_data every cycle while the frame drains.
   task automatic wait_drain();
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !dout_active) done = 1;
         else begin
            @(posedge clk); #1;
            din_data = 8'($urandom);
         end
      end
      chk("drain_leftover", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] bd, bl, br, ba;
      bit hit;
      int f0;

      tbl[0] = '{8'hA5, 12'b1010_1010_0101, 1'b0};
      tbl[1] = '{8'h00, 12'b1010_0000_0000, 1'b0};
      tbl[2] = '{8'hFF, 12'b1010_1111_1111, 1'b0};
      tbl[3] = '{8'h3C, 12'b1010_0011_1100, 1'b0};
      tbl[4] = '{8'h81, 12'b1010_1000_0001, 1'b0};
      tbl[5] = '{8'h07, 12'b1010_0000_0111, 1'b1};
      tbl[6] = '{8'h03, 12'b1010_0000_0011, 1'b0};
      tbl[7] = '{8'h80, 12'b1010_1000_0000, 1'b1};
      tbl[8] = '{8'h01, 12'b1010_0000_0001, 1'b1};

      resetn    = 1'b0;
      din_valid = 1'b0;
      din_data  = 8'h00;
      b_valid   = 1'b1;
      b_data    = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", din_ready, 0);
      chk("rst_dout", dout, 0);
      chk("rst_active", dout_active, 0);
      chk("rst_last", frame_last, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_b_dout", b_dout, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", din_ready, 0);

      // Short instance: 1,1,1 then exactly one idle zero, back to back
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bd[7-i] = b_dout;
         bl[7-i] = b_last;
         br[7-i] = b_ready;
         ba[7-i] = b_active;
         if (i == 0) chk("ready_after_release", din_ready, 1);
      end
      chk("b_dout_seq", bd, 8'b0111_0111);
      chk("b_active_seq", ba, 8'b0111_0111);
      chk("b_last_seq", bl, 8'b0001_0001);
      chk("b_ready_seq", br, 8'b1000_1000);

      // 0xA5: ready held low for the frame plus the gap
      f0 = frames_seen;
      drive_word(tbl[0]);
      for (int i = 0; i < F + GAP; i++) begin
         @(negedge clk);
         chk("ready_low", din_ready, 0);
      end
      @(negedge clk);
      chk("ready_back", din_ready, 1);
      chk("a5_drained", exp_q.size(), 0);
      chk("a5_frames", frames_seen - f0, 1);

      // Valid held high: 0x00 then 0xFF back to back
      f0 = frames_seen;
      @(posedge clk); #1;
      din_valid = 1'b1;
      din_data  = tbl[1].word;
      wait_ready(hit);
      if (hit) push_frame(tbl[1]);
      @(posedge clk); #1;
      din_data = tbl[2].word;
      wait_ready(hit);
      if (hit) push_frame(tbl[2]);
      @(posedge clk); #1;
      din_valid = 1'b0;
      wait_drain();
      chk("b2b_gap", last_gap, GAP + 1);
      chk("b2b_frames", frames_seen - f0, 2);

      // Reset during payload bit 3 of 0xFF
      drive_word(tbl[2]);
      repeat (8) @(posedge clk);
      #2;
      chk("pre_rst_dout", dout, 1);
      chk("pre_rst_active", dout_active, 1);
      resetn = 1'b0;
      #1;
      chk("abort_dout", dout, 0);
      chk("abort_active", dout_active, 0);
      chk("abort_ready", din_ready, 0);
      chk("abort_last", frame_last, 0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("rel_ready_pre", din_ready, 0);
      @(negedge clk);
      chk("rel_ready_post", din_ready, 1);
      f0 = frames_seen;
      drive_word(tbl[3]);
      wait_drain();
      chk("after_abort_frames", frames_seen - f0, 1);

      // Table sweep (includes 0x81 with din_data scrambled mid-frame, and the parity words)
      for (int k = 0; k < 9; k++) begin
         f0 = frames_seen;
         drive_word(tbl[k]);
         wait_drain();
         chk("tbl_frames", frames_seen - f0, 1);
      end

      repeat (4) @(negedge clk);
      chk("final_queue", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
